// File: rtl/addsub_64bit_seq.sv
// Two-pass 64-bit add/subtract sequencer driving an external 32-bit ripple adder.
// The low words go out first, the high words next, and the carry is chained between the two passes.
module addsub_64bit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_sub,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    output logic        add_mode,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        out_carry,
    output logic        out_overflow,
    output logic        out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        op_sub;
    logic        carry_mid;
    logic [31:0] lo_sum;

    assign in_ready = (state == IDLE);

    // The low half is held privately so the visible result only changes in HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            op_sub       <= 1'b0;
            carry_mid    <= 1'b0;
            lo_sum       <= '0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a   <= in_a;
                        op_b   <= in_b;
                        op_sub <= in_sub;
                        state  <= LO;
                    end
                end
                LO: begin
                    lo_sum    <= add_sum;
                    carry_mid <= add_cout;
                    state     <= HI;
                end
                HI: begin
                    out_result   <= {add_sum, lo_sum};
                    out_carry    <= add_cout;
                    out_overflow <= (op_a[63] == (op_b[63] ^ op_sub)) &&
                                    (add_sum[31] != op_a[63]);
                    out_zero     <= (lo_sum == 32'd0) && (add_sum == 32'd0);
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The adder operand B is sent raw, because the adder inverts it itself when add_mode is set.
    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        add_mode = 1'b0;
        case (state)
            LO: begin
                add_a    = op_a[31:0];
                add_b    = op_b[31:0];
                add_cin  = op_sub;
                add_mode = op_sub;
            end
            HI: begin
                add_a    = op_a[63:32];
                add_b    = op_b[63:32];
                add_cin  = carry_mid;
                add_mode = op_sub;
            end
            default: begin
                add_a    = '0;
                add_b    = '0;
                add_cin  = 1'b0;
                add_mode = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_addsub_64bit_seq.sv
// Testbench for addsub_64bit_seq, with a behavioural 32-bit adder attached and a plain-arithmetic reference model.
module tb_addsub_64bit_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_sub;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic        add_mode;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;

    int checks;
    int errors;

    addsub_64bit_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_mode     (add_mode),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ripple adder: inverts B in subtract mode.
    logic [32:0] adder_wide;
    always_comb begin
        adder_wide = {1'b0, add_a} + {1'b0, (add_mode ? ~add_b : add_b)} + {32'd0, add_cin};
        add_sum    = adder_wide[31:0];
        add_cout   = adder_wide[32];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelOp(input logic [63:0] a, input logic [63:0] b, input logic sub,
                           output logic [63:0] res, output logic carry, output logic ovf,
                           output logic zero, output logic cmid);
        logic [64:0] wide;
        logic [32:0] lo;
        if (sub) begin
            res   = a - b;
            carry = (a >= b);
            ovf   = (a[63] != b[63]) && (res[63] != a[63]);
            cmid  = (a[31:0] >= b[31:0]);
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            res   = wide[63:0];
            carry = wide[64];
            ovf   = (a[63] == b[63]) && (res[63] != a[63]);
            lo    = {1'b0, a[31:0]} + {1'b0, b[31:0]};
            cmid  = lo[32];
        end
        zero = (res == 64'd0);
    endtask

    task automatic checkAdderIdle(input string tag);
        checkVal({tag, "_drive"}, {add_a, add_b, add_cin, add_mode}, 64'd0);
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge where the DUT is in HI.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0] res;
        logic c, v, z, cm;
        modelOp(a, b, sub, res, c, v, z, cm);
        checkVal("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkVal("lo_in_ready", in_ready, 0);
        checkVal("lo_out_valid", out_valid, 0);
        checkVal("lo_add_a", add_a, a[31:0]);
        checkVal("lo_add_b", add_b, b[31:0]);
        checkVal("lo_add_cin", add_cin, sub);
        checkVal("lo_add_mode", add_mode, sub);
        @(negedge clk);
        checkVal("hi_out_valid", out_valid, 0);
        checkVal("hi_add_a", add_a, a[63:32]);
        checkVal("hi_add_b", add_b, b[63:32]);
        checkVal("hi_add_cin", add_cin, cm);
        checkVal("hi_add_mode", add_mode, sub);
    endtask

    task automatic checkOutput(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0] res;
        logic c, v, z, cm;
        modelOp(a, b, sub, res, c, v, z, cm);
        checkVal("out_valid", out_valid, 1);
        checkVal("in_ready_done", in_ready, 0);
        checkVal("out_result", out_result, res);
        checkVal("out_carry", out_carry, c);
        checkVal("out_overflow", out_overflow, v);
        checkVal("out_zero", out_zero, z);
        checkAdderIdle("done");
    endtask

    task automatic retire(input int stall);
        out_ready = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            checkVal("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkVal("post_out_valid", out_valid, 0);
        checkVal("post_in_ready", in_ready, 1);
        checkAdderIdle("idle");
    endtask

    task automatic runOp(input logic [63:0] a, input logic [63:0] b, input logic sub, input int stall);
        applyStimulus(a, b, sub);
        @(negedge clk);
        checkOutput(a, b, sub);
        retire(stall);
    endtask

    initial begin
        logic [63:0] ra, rb, na, nb;
        logic rs;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        #1;
        checkVal("rst_in_ready", in_ready, 1);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_result", out_result, 0);
        checkVal("rst_flags", {out_carry, out_overflow, out_zero}, 0);
        checkAdderIdle("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases
        runOp(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 0);
        runOp(64'd5, 64'd7, 1'b1, 1);
        runOp(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 0);
        runOp(64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 2);
        runOp(64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b1, 0);
        runOp(64'h80000000_00000000, 64'h1, 1'b1, 0);

        // Back-pressure with a competing request held on the input
        applyStimulus(64'hDEADBEEF_01234567, 64'h11111111_22222222, 1'b0);
        @(negedge clk);
        checkOutput(64'hDEADBEEF_01234567, 64'h11111111_22222222, 1'b0);
        na       = 64'hCAFEF00D_55555555;
        nb       = 64'h00000001_AAAAAAAB;
        in_valid = 1'b1;
        in_a     = na;
        in_b     = nb;
        in_sub   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput(64'hDEADBEEF_01234567, 64'h11111111_22222222, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkVal("bp_out_valid", out_valid, 0);
        checkVal("bp_in_ready", in_ready, 1);
        checkAdderIdle("bp_idle");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkVal("bp_lo_in_ready", in_ready, 0);
        checkVal("bp_lo_add_a", add_a, na[31:0]);
        checkVal("bp_lo_add_mode", add_mode, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput(na, nb, 1'b1);
        retire(0);

        // Reset asserted while in HI
        applyStimulus(64'h00000000_00000003, 64'h00000000_00000009, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst_out_valid", out_valid, 0);
        checkVal("mid_rst_in_ready", in_ready, 1);
        checkVal("mid_rst_result", out_result, 0);
        checkVal("mid_rst_flags", {out_carry, out_overflow, out_zero}, 0);
        checkAdderIdle("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp(64'd3, 64'd4, 1'b0, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            if (i % 6 == 0) rb = ra;
            if (i % 6 == 1) rb = ~ra;
            runOp(ra, rb, rs, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_64bit_seq.md
# addsub_64bit_seq

Sequential 64-bit add/subtract front end that sits directly upstream of the 32-bit ripple adder/subtractor. It accepts one 64-bit operation through a valid/ready handshake. It drives the low words and then the high words into the 32-bit adder over two consecutive cycles, chaining the carry between passes. It registers the 64-bit result with carry, overflow and zero flags behind a valid/ready output handshake.

## Interface
Parameters: none. Width is fixed at 64 bits, built from 2 × 32-bit passes.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept; high only in IDLE
- in_a  in  64  operand A
- in_b  in  64  operand B
- in_sub  in  1  0 = A+B, 1 = A−B
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B, raw (not inverted); the adder inverts it internally using mode
- add_cin  out  1  adder carry-in
- add_mode  out  1  adder mode (1 = subtract)
- add_sum  in  32  adder result, combinational from the add_* outputs
- add_cout  in  1  adder carry-out
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  64  A+B or A−B, mod 2^64
- out_carry  out  1  carry-out of bit 63; for subtract, 1 = no borrow (A ≥ B unsigned)
- out_overflow  out  1  signed two's-complement overflow
- out_zero  out  1  out_result == 0

## Operation
FSM states: IDLE, LO, HI, DONE.

- **IDLE**
  - in_ready = 1.
  - On in_valid: latch in_a, in_b and in_sub into operand registers, then go to LO.
- **LO**
  - Drive add_a = a[31:0], add_b = b[31:0], add_cin = sub, add_mode = sub.
  - At the clock edge: result[31:0] ← add_sum, carry_mid ← add_cout, go to HI.
- **HI**
  - Drive add_a = a[63:32], add_b = b[63:32], add_cin = carry_mid, add_mode = sub.
  - At the clock edge:
    - result[63:32] ← add_sum
    - out_carry ← add_cout
    - out_overflow ← (a[63] == (b[63]^sub)) && (add_sum[31] != a[63])
    - out_zero ← (result[31:0] == 0) && (add_sum == 0)
  - Go to DONE.
- **DONE**
  - out_valid = 1.
  - On out_ready: go to IDLE.
- **Adder drive outside LO/HI:** add_a, add_b, add_cin and add_mode are all 0.
- **Input side:** inputs are ignored outside IDLE; in_ready is a combinational decode of state == IDLE.
- **Output stability:** out_result and the flags are written only in HI. They hold their value until the next HI, including while out_valid && !out_ready.

## Timing
- **Reset:** asynchronous assert; deassert is synchronous to clk.
  - State ← IDLE.
  - Operand registers, carry_mid, out_result, out_carry, out_overflow and out_zero ← 0.
  - out_valid = 0; in_ready = 1 immediately.
- **Latency:** input handshake at edge N → LO during cycle N+1, HI during cycle N+2 → out_valid high after edge N+2.
- **Throughput:** if out_ready is held high, output handshake at edge N+3 and next input accept at edge N+4. Maximum rate is one op per 4 cycles.
- **Simultaneous out_ready and in_valid in DONE:** only the output handshake occurs. The input is not accepted until IDLE (in_ready = 0 in DONE).
- **Back-pressure:** out_valid stays high and all outputs stay frozen for any number of cycles while out_ready = 0.
- **Reset mid-operation (LO, HI or DONE):** the operation is aborted, no output is produced, and all outputs take their reset values.
- **Combinational path:** add_* outputs → external adder → add_sum/add_cout → registers. This path must close in one cycle.

## Test plan
1. **Carry chain:** add in_a=0x00000000_FFFFFFFF, in_b=0x1.
   - LO: add_cout=1.
   - Result 0x00000001_00000000, carry 0, overflow 0, zero 0.
2. **Borrow:** subtract in_a=5, in_b=7.
   - Result 0xFFFFFFFF_FFFFFFFE, carry 0, overflow 0, zero 0.
   - Check add_mode=1 and add_cin=1 in LO.
3. **Overflow and wrap:**
   - Add 0x7FFFFFFF_FFFFFFFF + 1 → 0x80000000_00000000, overflow 1, carry 0.
   - Add 0xFFFFFFFF_FFFFFFFF + 1 → 0, carry 1, zero 1, overflow 0.
4. **Equal subtract:** in_a = in_b = 0x12345678_9ABCDEF0, sub=1.
   - Result 0, zero 1, carry 1, overflow 0.
5. **Back-pressure and busy:**
   - Hold out_ready=0 for 5 cycles after out_valid: outputs stable, in_ready=0.
   - Keep in_valid high with new operands throughout; they must not be accepted until the cycle after the output handshake.
   - Adder drive is all-zero in IDLE/DONE.
6. **Reset mid-HI:**
   - Assert rst_n=0 during HI: out_valid=0 and outputs 0 without a clock, in_ready=1.
   - After release, a fresh add 3+4 returns 7 with 3-cycle latency.
